// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package im_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StLen,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  localparam logic [7:0]  SyncByteDefault = 8'hA5;
  localparam int unsigned ByteCntW        = 2;
  localparam int unsigned LenW            = 8;

endpackage

// File: rtl/im_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses the cycle after byte 3.
module im_loader_word_assembler
  import im_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                strobe_i,
  input  logic [7:0]          byte_i,
  output logic [ByteCntW-1:0] byte_cnt_o,
  output logic [31:0]         word_o,
  output logic                word_valid_o
);

  logic [ByteCntW-1:0] cnt_q, cnt_d;
  logic [23:0]         low_q, low_d;
  logic [31:0]         word_q, word_d;
  logic                valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    low_d   = low_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (strobe_i) begin
      cnt_d = cnt_q + 1'b1;
      case (cnt_q)
        2'd0: low_d[7:0]   = byte_i;
        2'd1: low_d[15:8]  = byte_i;
        2'd2: low_d[23:16] = byte_i;
        default: begin
          word_d  = {byte_i, low_q};
          valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      low_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign byte_cnt_o   = cnt_q;
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction RAM loader: framed byte stream in, one-word RAM writes out, CPU hold.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 5,
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 we,
  output logic [ADDR_BITS-1:0] waddr,
  output logic [31:0]          wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  state_e              state_q, state_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [LenW-1:0]     word_idx_q, word_idx_d;
  logic [7:0]          chk_q, chk_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic                done_q, error_q, hold_q;
  logic                accept, sync_hit, data_strobe, word_last;
  logic [ByteCntW-1:0] byte_cnt;

  assign rx_ready    = (state_q == StSync) || (state_q == StLen) ||
                       (state_q == StData) || (state_q == StChk);
  assign accept      = rx_valid && rx_ready;
  assign sync_hit    = accept && (state_q == StSync) && (rx_data == SYNC_BYTE);
  assign data_strobe = accept && (state_q == StData);
  assign word_last   = data_strobe && (byte_cnt == 2'd3);

  im_loader_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (sync_hit),
    .strobe_i     (data_strobe),
    .byte_i       (rx_data),
    .byte_cnt_o   (byte_cnt),
    .word_o       (wdata),
    .word_valid_o (we)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    chk_d      = chk_q;
    waddr_d    = waddr_q;
    case (state_q)
      StIdle, StDone, StErr: if (start) state_d = StSync;
      StSync: if (sync_hit) begin
        state_d    = StLen;
        word_idx_d = '0;
        chk_d      = '0;
      end
      StLen: if (accept) begin
        if ((rx_data == 8'd0) || ({24'd0, rx_data} > Depth)) begin
          state_d = StErr;
        end else begin
          len_d   = rx_data;
          state_d = StData;
        end
      end
      StData: if (data_strobe) begin
        chk_d = chk_q ^ rx_data;
        if (word_last) begin
          waddr_d    = word_idx_q[ADDR_BITS-1:0];
          word_idx_d = word_idx_q + 1'b1;
          if (word_idx_q == len_q - 1'b1) state_d = StChk;
        end
      end
      StChk: if (accept) state_d = (rx_data == chk_q) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
  end

  // Status flags follow the state being entered, so they settle one cycle after the decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_idx_q <= '0;
      chk_q      <= '0;
      waddr_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      chk_q      <= chk_d;
      waddr_q    <= waddr_d;
      done_q     <= (state_d == StDone);
      error_q    <= (state_d == StErr);
      hold_q     <= (state_d != StDone);
    end
  end

  assign waddr    = waddr_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cpu_hold = hold_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: framed loads, bad frames, gaps and mid-frame reset.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        we, cpu_hold, done, error;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  frame[$];

  im_loader #(.ADDR_BITS(5), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_addr.push_back(32'(waddr));
      wr_data.push_back(wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    foreach (frame[i]) begin
      send_byte(frame[i]);
      repeat (gap) step();
    end
  endtask

  task automatic expect_status(input string t, input logic d, input logic e, input logic h);
    repeat (2) @(negedge clk);
    check({t, "_done"}, 32'(done), 32'(d));
    check({t, "_error"}, 32'(error), 32'(e));
    check({t, "_hold"}, 32'(cpu_hold), 32'(h));
    step();
  endtask

  task automatic expect_writes(input string t, input int n, input logic [31:0] a0,
                               input logic [31:0] d0, input logic [31:0] a1,
                               input logic [31:0] d1);
    check({t, "_wr_count"}, 32'(wr_addr.size()), 32'(n));
    if (n > 0 && wr_addr.size() > 0) begin
      check({t, "_waddr0"}, wr_addr[0], a0);
      check({t, "_wdata0"}, wr_data[0], d0);
    end
    if (n > 1 && wr_addr.size() > 1) begin
      check({t, "_waddr1"}, wr_addr[1], a1);
      check({t, "_wdata1"}, wr_data[1], d1);
    end
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic expect_reset_values(input string t);
    check({t, "_we"}, 32'(we), 32'd0);
    check({t, "_waddr"}, 32'(waddr), 32'd0);
    check({t, "_wdata"}, wdata, 32'd0);
    check({t, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({t, "_hold"}, 32'(cpu_hold), 32'd1);
    check({t, "_done"}, 32'(done), 32'd0);
    check({t, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic load_normal_frame();
    frame = '{8'hA5, 8'h02, 8'h93, 8'h02, 8'h00, 8'h00, 8'h93, 8'h03, 8'h00, 8'h00, 8'h01};
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    expect_reset_values("reset");
    step();
    reset = 1'b0;
    step();

    // Normal load at one byte per cycle
    pulse_start();
    check("sync_rx_ready", 32'(rx_ready), 32'd1);
    load_normal_frame();
    send_frame(0);
    expect_status("normal", 1'b1, 1'b0, 1'b0);
    expect_writes("normal", 2, 32'd0, 32'h00000293, 32'd1, 32'h00000393);

    // Restart from DONE clears status on the same edge; garbage precedes sync
    pulse_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_hold", 32'(cpu_hold), 32'd1);
    frame = '{8'h00, 8'hFF, 8'h5A};
    send_frame(0);
    load_normal_frame();
    send_frame(0);
    expect_status("garbage", 1'b1, 1'b0, 1'b0);
    expect_writes("garbage", 2, 32'd0, 32'h00000293, 32'd1, 32'h00000393);

    // Zero length
    pulse_start();
    frame = '{8'hA5, 8'h00};
    send_frame(0);
    expect_status("len0", 1'b0, 1'b1, 1'b1);
    expect_writes("len0", 0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Length above depth
    pulse_start();
    check("restart_error", 32'(error), 32'd0);
    frame = '{8'hA5, 8'h21};
    send_frame(0);
    expect_status("len33", 1'b0, 1'b1, 1'b1);
    expect_writes("len33", 0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Bad checksum after one good word
    pulse_start();
    frame = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};
    send_frame(0);
    expect_status("badchk", 1'b0, 1'b1, 1'b1);
    expect_writes("badchk", 1, 32'd0, 32'h00000013, 32'd0, 32'd0);

    // Valid gaps of two idle cycles between bytes
    pulse_start();
    load_normal_frame();
    send_frame(2);
    expect_status("gaps", 1'b1, 1'b0, 1'b0);
    expect_writes("gaps", 2, 32'd0, 32'h00000293, 32'd1, 32'h00000393);

    // Reset right after the 6th byte, cancelling the first write
    pulse_start();
    frame = '{8'hA5, 8'h02, 8'h93, 8'h02, 8'h00, 8'h00};
    send_frame(0);
    reset = 1'b1;
    @(negedge clk);
    expect_reset_values("midreset");
    expect_writes("midreset", 0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    reset = 1'b0;
    step();
    pulse_start();
    load_normal_frame();
    send_frame(0);
    expect_status("reload", 1'b1, 1'b0, 1'b0);
    expect_writes("reload", 2, 32'd0, 32'h00000293, 32'd1, 32'h00000393);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
